alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the combinational Hack-style ALU.
- Keeps the same six-bit control semantics {zx,nx,zy,ny,f,no} and the zr/ng flags.
- Adds a WIDTH parameter, a valid/ready handshake with backpressure, an in-order tag passthrough, a signed-overflow flag, and an internal accumulator usable as the x operand.
- Sits between the instruction sequencer and the register writeback.

Parameters:
- WIDTH, 16, operand and result width in bits (>=2).
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  operation accepted when in_valid && in_ready.
- in_x  input  WIDTH  x operand; ignored when in_src_acc=1.
- in_y  input  WIDTH  y operand.
- in_ctrl  input  6  {zx,nx,zy,ny,f,no}; bit 5 = zx.
- in_src_acc  input  1  when 1, x is taken from the accumulator.
- in_tag  input  TAG_W  opaque tag.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- out_result  output  WIDTH  ALU result.
- out_zr  output  1  result == 0.
- out_ng  output  1  result MSB.
- out_ov  output  1  signed overflow of the add (f=1) before no; 0 when f=0.
- out_tag  output  TAG_W  tag of this result.
- acc_value  output  WIDTH  current accumulator contents.

Behaviour:
- Reset (rst_n low, asynchronous): all valid bits, out_* and acc_value go to 0. in_ready is 0 while rst_n is low, then combinationally 1 once the pipeline is empty. In-flight operations are discarded, not completed.
- Datapath, all arithmetic modulo 2^WIDTH:
  - x' = zx ? 0 : x; x' = nx ? ~x' : x'. Same for y with zy/ny.
  - r = f ? x'+y' : x'&y'; r = no ? ~r : r.
- ov = f & (x'[MSB]==y'[MSB]) & (sum[MSB]!=x'[MSB]). ov is computed pre-no and is not inverted by no.
- Stage 1 registers x', y', f, no and tag.
- Stage 2 registers r, zr, ng, ov and tag. Outputs come directly from the stage-2 registers; no combinational input-to-output path.
- Latency: accepted at edge N, result valid after edge N+2 while out_ready=1. Throughput is 1 op/cycle.
- Backpressure:
  - Stage 2 holds while out_valid && !out_ready.
  - Stage 1 advances when stage 2 is empty or draining that cycle.
  - in_ready = (stage 1 empty || stage 1 advancing) && !hazard.
  - out_* stay stable while out_valid && !out_ready.
  - Two ops are buffered maximum.
- Ordering: results leave in acceptance order with their tags unchanged.
- Accumulator:
  - acc is loaded with out_result on every output handshake, regardless of in_src_acc.
  - hazard = in_valid && in_src_acc && (stage 1 valid || stage 2 valid). It deasserts in_ready, so an acc-sourced op always sees the acc value of the last completed op.
- Simultaneous events:
  - An output handshake and an input acceptance in the same cycle are both honoured.
  - A hazard op waits until the cycle after the output handshake that empties the pipeline (acc updated at that edge).
- Zero-width stall: in_valid held without a handshake must not change state.

Decomposition:
- Shared package alu_pkg holds:
  - the ctrl bit-index constants (CTRL_ZX=5 … CTRL_NO=0);
  - named control codes for the Hack functions (ALU_ZERO=6'b101010, ALU_ONE=6'b111111, ALU_NEG1=6'b111010, ALU_X=6'b001100, ALU_ADD=6'b000010, ALU_SUB_XY=6'b010011, ALU_AND=6'b000000, ALU_OR=6'b010101).
- One sub-module: alu_pipe_stage, a valid/ready pipeline register with hold. It is instantiated twice with different payload widths.
- The combinational preprocess and function logic stay inline.

Test Plan:
- WIDTH=16, x=2, y=2, sweep ctrl 0..63 with out_ready=1 -> every result matches the reference model two cycles after acceptance. ALU_ADD gives 4; ALU_SUB_XY gives 0 with zr=1; ALU_NEG1 gives 0xFFFF with ng=1.
- x=0x7FFF, y=1, ALU_ADD -> result 0x8000, ng=1, ov=1. x=0x8000, y=0xFFFF, ALU_ADD -> 0x7FFF, ov=1, ng=0.
- Three back-to-back ops (tags 1,2,3), out_ready=0 for 4 cycles -> in_ready drops after two accepts. out_result/out_tag are stable on tag 1. After out_ready=1, tags appear 1,2,3 on consecutive cycles.
- Accumulator hazard:
  - op A: x=5, y=3, ALU_ADD.
  - Next cycle, op B: src_acc=1, y=1, ALU_ADD.
  - Expected: in_ready=0 for B until A's handshake; acc_value=8; B's result = 9 with acc_value=9 after B's handshake.
- Reset mid-operation: two ops in flight, rst_n pulled low between clock edges -> out_valid=0 and acc_value=0 immediately. After release, no stale result appears, and a new ALU_ONE op yields 1 at latency 2.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared constants for the pipelined Hack-style ALU: control-word
//             bit positions and named control codes for the common functions.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

   // Bit positions inside the six-bit control word {zx,nx,zy,ny,f,no}
   localparam int CTRL_ZX = 5;
   localparam int CTRL_NX = 4;
   localparam int CTRL_ZY = 3;
   localparam int CTRL_NY = 2;
   localparam int CTRL_F  = 1;
   localparam int CTRL_NO = 0;

   localparam int CTRL_W  = 6;

   // Named control codes for the classic Hack functions
   localparam logic [CTRL_W-1:0] ALU_ZERO   = 6'b101010;
   localparam logic [CTRL_W-1:0] ALU_ONE    = 6'b111111;
   localparam logic [CTRL_W-1:0] ALU_NEG1   = 6'b111010;
   localparam logic [CTRL_W-1:0] ALU_X      = 6'b001100;
   localparam logic [CTRL_W-1:0] ALU_ADD    = 6'b000010;
   localparam logic [CTRL_W-1:0] ALU_SUB_XY = 6'b010011;
   localparam logic [CTRL_W-1:0] ALU_AND    = 6'b000000;
   localparam logic [CTRL_W-1:0] ALU_OR     = 6'b010101;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe_stage
//  Purpose  : One valid/ready pipeline register.  It accepts a new payload
//             whenever it is empty or its current payload leaves this cycle,
//             and holds both valid and payload while downstream stalls.
//  Revision : 1.0  initial release
// ============================================================================
module alu_pipe_stage #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   // upstream side
   input  logic              up_valid,
   output logic              up_ready,
   input  logic [DATA_W-1:0] up_data,
   // downstream side
   output logic              dn_valid,
   input  logic              dn_ready,
   output logic [DATA_W-1:0] dn_data
);

   logic              valid_q;
   logic [DATA_W-1:0] data_q;
   logic              load;

   // Room exists when empty, or when the held payload is consumed this cycle
   always_comb begin
      up_ready = !valid_q || dn_ready;
      load     = up_valid && up_ready;
   end

   // Register the payload; hold everything while stalled with valid set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (load) begin
         valid_q <= 1'b1;
         data_q  <= up_data;
      end else if (dn_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign dn_valid = valid_q;
   assign dn_data  = data_q;

endmodule : alu_pipe_stage
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe
//  Purpose  : Two-stage pipelined Hack-style ALU with valid/ready handshake,
//             tag passthrough, signed-overflow flag and an accumulator that
//             can replace the x operand.
//             Stage 1 holds the preprocessed operands x'/y' plus f/no/tag.
//             Stage 2 holds the final result and flags, driving the outputs.
//  Revision : 1.0  initial release
// ============================================================================
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int TAG_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   // request side
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_x,
   input  logic [WIDTH-1:0]  in_y,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              in_src_acc,
   input  logic [TAG_W-1:0]  in_tag,
   // result side
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_result,
   output logic              out_zr,
   output logic              out_ng,
   output logic              out_ov,
   output logic [TAG_W-1:0]  out_tag,
   // accumulator observation
   output logic [WIDTH-1:0]  acc_value
);

   localparam int MSB  = WIDTH - 1;
   // stage-1 payload: {x', y', f, no, tag}
   localparam int S1_W = 2 * WIDTH + 2 + TAG_W;
   // stage-2 payload: {r, zr, ng, ov, tag}
   localparam int S2_W = WIDTH + 3 + TAG_W;

   // ------------------------------------------------------------------------
   // Accumulator and handshake control
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0] acc_q;
   logic             s1_valid;
   logic             s1_up_ready;
   logic             s2_valid;
   logic             s2_up_ready;
   logic             hazard;
   logic             accept;
   logic             out_fire;

   // An acc-sourced op must wait until every older op has left, so the
   // accumulator it reads is the result of the last completed op.
   always_comb begin
      hazard   = in_valid && in_src_acc && (s1_valid || s2_valid);
      in_ready = rst_n && s1_up_ready && !hazard;
      accept   = in_valid && in_ready;
      out_fire = out_valid && out_ready;
   end

   // Accumulator captures every result as it is handed to the consumer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else if (out_fire) begin
         acc_q <= out_result;
      end
   end

   assign acc_value = acc_q;

   // ------------------------------------------------------------------------
   // Stage 1 input: operand selection and zero/negate preprocessing
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0] x_src;
   logic [WIDTH-1:0] x_zeroed;
   logic [WIDTH-1:0] y_zeroed;
   logic [WIDTH-1:0] x_pre;
   logic [WIDTH-1:0] y_pre;
   logic [S1_W-1:0]  s1_in;

   // Build x' and y' from the selected operands and the zx/nx/zy/ny bits
   always_comb begin
      x_src    = in_src_acc ? acc_q : in_x;
      x_zeroed = in_ctrl[CTRL_ZX] ? '0 : x_src;
      x_pre    = in_ctrl[CTRL_NX] ? ~x_zeroed : x_zeroed;
      y_zeroed = in_ctrl[CTRL_ZY] ? '0 : in_y;
      y_pre    = in_ctrl[CTRL_NY] ? ~y_zeroed : y_zeroed;
      s1_in    = {x_pre, y_pre, in_ctrl[CTRL_F], in_ctrl[CTRL_NO], in_tag};
   end

   logic [S1_W-1:0] s1_q;

   alu_pipe_stage #(
      .DATA_W (S1_W)
   ) u_stage1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (accept),
      .up_ready (s1_up_ready),
      .up_data  (s1_in),
      .dn_valid (s1_valid),
      .dn_ready (s2_up_ready),
      .dn_data  (s1_q)
   );

   // ------------------------------------------------------------------------
   // Stage 2 input: function, optional inversion, flags
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0] s1_x;
   logic [WIDTH-1:0] s1_y;
   logic             s1_f;
   logic             s1_no;
   logic [TAG_W-1:0] s1_tag;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] fn_res;
   logic [WIDTH-1:0] res;
   logic             res_zr;
   logic             res_ng;
   logic             res_ov;
   logic [S2_W-1:0]  s2_in;

   // Add or AND the preprocessed operands; overflow is judged on the raw
   // sum and is deliberately unaffected by the final 'no' inversion.
   always_comb begin
      {s1_x, s1_y, s1_f, s1_no, s1_tag} = s1_q;
      sum    = s1_x + s1_y;
      fn_res = s1_f ? sum : (s1_x & s1_y);
      res    = s1_no ? ~fn_res : fn_res;
      res_zr = (res == '0);
      res_ng = res[MSB];
      res_ov = s1_f && (s1_x[MSB] == s1_y[MSB]) && (sum[MSB] != s1_x[MSB]);
      s2_in  = {res, res_zr, res_ng, res_ov, s1_tag};
   end

   logic [S2_W-1:0] s2_q;

   alu_pipe_stage #(
      .DATA_W (S2_W)
   ) u_stage2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (s1_valid),
      .up_ready (s2_up_ready),
      .up_data  (s2_in),
      .dn_valid (s2_valid),
      .dn_ready (out_ready),
      .dn_data  (s2_q)
   );

   // Outputs come straight from the stage-2 register
   always_comb begin
      out_valid = s2_valid;
      {out_result, out_zr, out_ng, out_ov, out_tag} = s2_q;
   end

endmodule : alu_pipe
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_pipe
//  Purpose  : Directed self-checking bench for alu_pipe (WIDTH=16, TAG_W=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_pipe;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_x;
   logic [15:0] in_y;
   logic [5:0]  in_ctrl;
   logic        in_src_acc;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic        out_zr;
   logic        out_ng;
   logic        out_ov;
   logic [3:0]  out_tag;
   logic [15:0] acc_value;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] r;
      logic        zr;
      logic        ng;
      logic        ov;
      logic [3:0]  tag;
      logic [5:0]  ctrl;
      int          cyc;
   } exp_t;

   alu_pipe #(
      .WIDTH (16),
      .TAG_W (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_x       (in_x),
      .in_y       (in_y),
      .in_ctrl    (in_ctrl),
      .in_src_acc (in_src_acc),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_zr     (out_zr),
      .out_ng     (out_ng),
      .out_ov     (out_ov),
      .out_tag    (out_tag),
      .acc_value  (acc_value)
   );

   always #5 clk = ~clk;

   // Reference ALU: returns {r, zr, ng, ov}
   function automatic logic [18:0] alu_ref(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
      logic [15:0] a, b, s, r;
      logic        ov;
      a = c[5] ? 16'h0000 : x;
      if (c[4]) a = ~a;
      b = c[3] ? 16'h0000 : y;
      if (c[2]) b = ~b;
      s  = a + b;
      r  = c[1] ? s : (a & b);
      ov = c[1] && (a[15] == b[15]) && (s[15] != a[15]);
      if (c[0]) r = ~r;
      return {r, (r == 16'h0000), r[15], ov};
   endfunction

   task automatic drive_op(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c,
                           input logic src, input logic [3:0] tag);
      in_valid   = 1'b1;
      in_x       = x;
      in_y       = y;
      in_ctrl    = c;
      in_src_acc = src;
      in_tag     = tag;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_ctrl = '0;
      in_src_acc = 1'b0; in_tag = '0; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({in_ready, out_valid, acc_value, out_result, out_tag} !== {1'b0, 1'b0, 16'h0, 16'h0, 4'h0}) begin
         bad++;
         $display("FAIL reset_state: got rdy=%b ov=%b acc=%h res=%h tag=%h want all 0",
                  in_ready, out_valid, acc_value, out_result, out_tag);
      end
      rst_n = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_release_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_ctrl_sweep();
      exp_t        q[$];
      exp_t        e;
      logic [18:0] m;
      int          issued = 0;
      int          cyc = 0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      while ((issued < 64 || q.size() != 0) && cyc < 300) begin
         if (issued < 64) drive_op(16'd2, 16'd2, 6'(issued), 1'b0, 4'(issued));
         else in_valid = 1'b0;
         @(negedge clk);
         if (out_valid) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL sweep_unexpected: got result=%h with nothing expected", out_result);
            end else begin
               e = q.pop_front();
               if ({out_result, out_zr, out_ng, out_ov, out_tag} !== {e.r, e.zr, e.ng, e.ov, e.tag}
                   || cyc != e.cyc + 2) begin
                  bad++;
                  $display("FAIL sweep_ctrl_%0d: got r=%h zr=%b ng=%b ov=%b tag=%h cyc=%0d want r=%h zr=%b ng=%b ov=%b tag=%h cyc=%0d",
                           e.ctrl, out_result, out_zr, out_ng, out_ov, out_tag, cyc,
                           e.r, e.zr, e.ng, e.ov, e.tag, e.cyc + 2);
               end
               if (e.ctrl == ALU_ADD) begin
                  total++;
                  if (out_result !== 16'd4) begin
                     bad++;
                     $display("FAIL sweep_add: got %h want 0004", out_result);
                  end
               end
               if (e.ctrl == ALU_SUB_XY) begin
                  total++;
                  if ({out_result, out_zr} !== {16'h0000, 1'b1}) begin
                     bad++;
                     $display("FAIL sweep_sub: got r=%h zr=%b want r=0000 zr=1", out_result, out_zr);
                  end
               end
               if (e.ctrl == ALU_NEG1) begin
                  total++;
                  if ({out_result, out_ng} !== {16'hFFFF, 1'b1}) begin
                     bad++;
                     $display("FAIL sweep_neg1: got r=%h ng=%b want r=ffff ng=1", out_result, out_ng);
                  end
               end
            end
         end
         if (in_valid && in_ready) begin
            m      = alu_ref(in_x, in_y, in_ctrl);
            e.r    = m[18:3];
            e.zr   = m[2];
            e.ng   = m[1];
            e.ov   = m[0];
            e.tag  = in_tag;
            e.ctrl = in_ctrl;
            e.cyc  = cyc;
            q.push_back(e);
            issued++;
         end
         cyc++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      total++;
      if (issued != 64 || q.size() != 0) begin
         bad++;
         $display("FAIL sweep_timeout: got issued=%0d pending=%0d want issued=64 pending=0",
                  issued, q.size());
      end
   endtask

   task automatic test_overflow();
      // 0x7FFF + 1
      drive_op(16'h7FFF, 16'h0001, ALU_ADD, 1'b0, 4'hA);
      @(posedge clk); #1; in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({out_valid, out_result, out_ng, out_ov, out_tag} !== {1'b1, 16'h8000, 1'b1, 1'b1, 4'hA}) begin
         bad++;
         $display("FAIL ov_pos: got v=%b r=%h ng=%b ov=%b tag=%h want v=1 r=8000 ng=1 ov=1 tag=a",
                  out_valid, out_result, out_ng, out_ov, out_tag);
      end
      @(posedge clk); #1;
      // 0x8000 + 0xFFFF
      drive_op(16'h8000, 16'hFFFF, ALU_ADD, 1'b0, 4'hB);
      @(posedge clk); #1; in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({out_valid, out_result, out_ng, out_ov, out_tag} !== {1'b1, 16'h7FFF, 1'b0, 1'b1, 4'hB}) begin
         bad++;
         $display("FAIL ov_neg: got v=%b r=%h ng=%b ov=%b tag=%h want v=1 r=7fff ng=0 ov=1 tag=b",
                  out_valid, out_result, out_ng, out_ov, out_tag);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      drive_op(16'd10, 16'd1, ALU_ADD, 1'b0, 4'd1);
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_accept1: got ready=%b want 1", in_ready);
      end
      @(posedge clk); #1;
      drive_op(16'd20, 16'd2, ALU_ADD, 1'b0, 4'd2);
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_accept2: got ready=%b want 1", in_ready);
      end
      @(posedge clk); #1;
      drive_op(16'd30, 16'd3, ALU_ADD, 1'b0, 4'd3);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if ({in_ready, out_valid, out_result, out_tag} !== {1'b0, 1'b1, 16'd11, 4'd1}) begin
            bad++;
            $display("FAIL bp_hold_%0d: got rdy=%b v=%b r=%h tag=%h want rdy=0 v=1 r=000b tag=1",
                     i, in_ready, out_valid, out_result, out_tag);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_release_ready: got %b want 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({out_valid, out_result, out_tag} !== {1'b1, 16'd22, 4'd2}) begin
         bad++;
         $display("FAIL bp_order2: got v=%b r=%h tag=%h want v=1 r=0016 tag=2", out_valid, out_result, out_tag);
      end
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({out_valid, out_result, out_tag} !== {1'b1, 16'd33, 4'd3}) begin
         bad++;
         $display("FAIL bp_order3: got v=%b r=%h tag=%h want v=1 r=0021 tag=3", out_valid, out_result, out_tag);
      end
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({out_valid, acc_value} !== {1'b0, 16'd33}) begin
         bad++;
         $display("FAIL bp_drain: got v=%b acc=%h want v=0 acc=0021", out_valid, acc_value);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_acc_hazard();
      out_ready = 1'b1;
      drive_op(16'd5, 16'd3, ALU_ADD, 1'b0, 4'd5);
      @(posedge clk); #1;
      drive_op(16'h1234, 16'd1, ALU_ADD, 1'b1, 4'd6);
      #1;
      total++;
      if (in_ready !== 1'b0) begin
         bad++;
         $display("FAIL hz_block_s1: got ready=%b want 0", in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({in_ready, out_valid, out_result} !== {1'b0, 1'b1, 16'd8}) begin
         bad++;
         $display("FAIL hz_block_s2: got rdy=%b v=%b r=%h want rdy=0 v=1 r=0008", in_ready, out_valid, out_result);
      end
      @(posedge clk); #1;
      total++;
      if ({acc_value, in_ready, out_valid} !== {16'd8, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL hz_acc8: got acc=%h rdy=%b v=%b want acc=0008 rdy=1 v=0", acc_value, in_ready, out_valid);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_src_acc = 1'b0;
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({out_valid, out_result, out_tag} !== {1'b1, 16'd9, 4'd6}) begin
         bad++;
         $display("FAIL hz_result: got v=%b r=%h tag=%h want v=1 r=0009 tag=6", out_valid, out_result, out_tag);
      end
      @(posedge clk); #1;
      total++;
      if (acc_value !== 16'd9) begin
         bad++;
         $display("FAIL hz_acc9: got %h want 0009", acc_value);
      end
   endtask

   task automatic test_reset_midop();
      out_ready = 1'b0;
      drive_op(16'd1, 16'd1, ALU_ADD, 1'b0, 4'd7);
      @(posedge clk); #1;
      drive_op(16'd2, 16'd2, ALU_ADD, 1'b0, 4'd8);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({out_valid, out_tag} !== {1'b1, 4'd7}) begin
         bad++;
         $display("FAIL rst_precond: got v=%b tag=%h want v=1 tag=7", out_valid, out_tag);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({out_valid, acc_value, out_result, in_ready} !== {1'b0, 16'h0, 16'h0, 1'b0}) begin
         bad++;
         $display("FAIL rst_async: got v=%b acc=%h r=%h rdy=%b want v=0 acc=0000 r=0000 rdy=0",
                  out_valid, acc_value, out_result, in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      out_ready = 1'b1;
      drive_op(16'h0055, 16'h0066, ALU_ONE, 1'b0, 4'd9);
      #1;
      total++;
      if ({in_ready, out_valid} !== {1'b1, 1'b0}) begin
         bad++;
         $display("FAIL rst_after: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL rst_no_stale: got v=%b r=%h want v=0", out_valid, out_result);
      end
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({out_valid, out_result, out_tag} !== {1'b1, 16'd1, 4'd9}) begin
         bad++;
         $display("FAIL rst_one: got v=%b r=%h tag=%h want v=1 r=0001 tag=9", out_valid, out_result, out_tag);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_ctrl_sweep();
      test_overflow();
      test_back_to_back();
      test_acc_hazard();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_alu_pipe
`default_nettype wire
